// File: rtl/wb_wport_arb.sv
// wb_wport_arb: shares one register-file write port between the pipeline write-back and a
// long-latency unit result queue; define WB_ARB_BYPASS_EN for 0-cycle LU writes when idle.
module wb_wport_arb #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wb_wen,
   input  logic [4:0]  i_wb_waddr,
   input  logic [31:0] i_wb_wdata,
   input  logic        i_lu_vld,
   input  logic [4:0]  i_lu_waddr,
   input  logic [31:0] i_lu_wdata,
   output logic        o_lu_rdy,
   output logic        o_rd_wen,
   output logic [4:0]  o_rd_waddr,
   output logic [31:0] o_rd_wdata,
   output logic        o_stall,
   output logic [31:0] o_pend_mask
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       stv_q, stv_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [4:0]       addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic             empty, wb_ok, pop, acc, byp, push;
   always_comb begin
      empty    = cnt_q == '0;
      o_stall  = !i_rst && stv_q == 4'(STARVE_MAX);
      o_lu_rdy = !i_rst && cnt_q < CW'(DEPTH);
      // a stalled pipeline is holding its instruction, so its write is ignored
      wb_ok    = !i_rst && !o_stall && i_wb_wen && i_wb_waddr != '0;
      pop      = !i_rst && !empty && !wb_ok;
      acc      = i_lu_vld && o_lu_rdy;
`ifdef WB_ARB_BYPASS_EN
      byp      = acc && i_lu_waddr != '0 && empty && !wb_ok && !o_stall;
`else
      byp      = 1'b0;
`endif
      push     = acc && i_lu_waddr != '0 && !byp;
      o_rd_wen   = wb_ok || pop || byp;
      o_rd_waddr = wb_ok ? i_wb_waddr : pop ? addr_q[rd_q] : byp ? i_lu_waddr : '0;
      o_rd_wdata = wb_ok ? i_wb_wdata : pop ? data_q[rd_q] : byp ? i_lu_wdata : '0;
      o_pend_mask = '0;
      for (int k = 0; k < DEPTH; k++)
         if (vld_q[k] && !i_rst) o_pend_mask[addr_q[k]] = 1'b1;
      wr_d  = push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
      rd_d  = pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      vld_d = vld_q;
      if (pop) vld_d[rd_q] = 1'b0;
      if (push) vld_d[wr_q] = 1'b1;
      stv_d = (empty || pop) ? '0 : stv_q == 4'(STARVE_MAX) ? stv_q : stv_q + 1'b1;
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         vld_q <= '0;
         stv_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         vld_q <= vld_d;
         stv_q <= stv_d;
      end
   end
   always_ff @(posedge i_clk) begin
      if (push) begin
         addr_q[wr_q] <= i_lu_waddr;
         data_q[wr_q] <= i_lu_wdata;
      end
   end
endmodule

// File: tb/tb_wb_wport_arb.sv
// tb_wb_wport_arb: directed checks of wb_wport_arb with DEPTH=2, STARVE_MAX=4.
module tb_wb_wport_arb;
   logic        i_clk = 1'b0, i_rst = 1'b1;
   logic        i_wb_wen, i_lu_vld;
   logic [4:0]  i_wb_waddr, i_lu_waddr;
   logic [31:0] i_wb_wdata, i_lu_wdata;
   logic        o_lu_rdy, o_rd_wen, o_stall;
   logic [4:0]  o_rd_waddr;
   logic [31:0] o_rd_wdata, o_pend_mask;
   int          n_cmp = 0, n_bad = 0;
   int          seen, nbad_addr;
   logic [4:0]  got [2];
   wb_wport_arb #(.DEPTH(2), .STARVE_MAX(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_wb_wen(i_wb_wen), .i_wb_waddr(i_wb_waddr), .i_wb_wdata(i_wb_wdata),
      .i_lu_vld(i_lu_vld), .i_lu_waddr(i_lu_waddr), .i_lu_wdata(i_lu_wdata),
      .o_lu_rdy(o_lu_rdy), .o_rd_wen(o_rd_wen), .o_rd_waddr(o_rd_waddr),
      .o_rd_wdata(o_rd_wdata), .o_stall(o_stall), .o_pend_mask(o_pend_mask)
   );
   always #5 i_clk = ~i_clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      i_wb_wen = wen; i_wb_waddr = wa; i_wb_wdata = wd;
      i_lu_vld = lv;  i_lu_waddr = la; i_lu_wdata = ld;
      #1;
   endtask
   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask
   initial begin
      // reset: a pipeline write must not leak through
      drive(1, 5'd3, 32'h5, 1, 5'd4, 32'h6);
      #1;
      chk("rst_wen", o_rd_wen, 0);
      chk("rst_rdy", o_lu_rdy, 0);
      chk("rst_stall", o_stall, 0);
      chk("rst_mask", o_pend_mask, 0);
      chk("rst_waddr", o_rd_waddr, 0);
      chk("rst_wdata", o_rd_wdata, 0);
      tick;
      i_rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      chk("post_rst_rdy", o_lu_rdy, 1);
      chk("idle_wen", o_rd_wen, 0);
      // single LU result with idle pipeline
      drive(0, 0, 0, 1, 5'd5, 32'h1234);
`ifdef WB_ARB_BYPASS_EN
      chk("a_byp_wen", o_rd_wen, 1);
      chk("a_byp_waddr", o_rd_waddr, 5);
      chk("a_byp_wdata", o_rd_wdata, 32'h1234);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk("a_byp_next_wen", o_rd_wen, 0);
      chk("a_byp_mask", o_pend_mask, 0);
`else
      chk("a_c0_wen", o_rd_wen, 0);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk("a_c1_wen", o_rd_wen, 1);
      chk("a_c1_waddr", o_rd_waddr, 5);
      chk("a_c1_wdata", o_rd_wdata, 32'h1234);
      chk("a_c1_mask", o_pend_mask, 32'h20);
`endif
      tick;
      chk("a_done_mask", o_pend_mask, 0);
      chk("a_done_wen", o_rd_wen, 0);
      // starvation under continuous pipeline writes
      drive(1, 5'd1, 32'hAAAA, 1, 5'd7, 32'h77);
      chk("b_c0_waddr", o_rd_waddr, 1);
      tick;
      drive(1, 5'd1, 32'hAAAA, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("b_c%0d_stall", i), o_stall, 0);
         chk($sformatf("b_c%0d_waddr", i), o_rd_waddr, 1);
         chk($sformatf("b_c%0d_mask", i), o_pend_mask, 32'h80);
         tick;
      end
      chk("b_c5_stall", o_stall, 1);
      chk("b_c5_waddr", o_rd_waddr, 7);
      chk("b_c5_wdata", o_rd_wdata, 32'h77);
      tick;
      chk("b_c6_stall", o_stall, 0);
      chk("b_c6_waddr", o_rd_waddr, 1);
      chk("b_c6_mask", o_pend_mask, 0);
      // full queue, held third push, FIFO order
      drive(1, 5'd1, 32'hAAAA, 1, 5'd2, 32'h22);
      chk("c_c0_rdy", o_lu_rdy, 1);
      tick;
      drive(1, 5'd1, 32'hAAAA, 1, 5'd3, 32'h33);
      chk("c_c1_rdy", o_lu_rdy, 1);
      tick;
      drive(1, 5'd1, 32'hAAAA, 1, 5'd4, 32'h44);
      chk("c_c2_rdy", o_lu_rdy, 0);
      chk("c_c2_mask", o_pend_mask, 32'h0C);
      tick;
      tick;
      tick;
      chk("c_c5_stall", o_stall, 1);
      chk("c_c5_waddr", o_rd_waddr, 2);
      chk("c_c5_rdy_no_pushthrough", o_lu_rdy, 0);
      tick;
      chk("c_c6_stall", o_stall, 0);
      chk("c_c6_rdy", o_lu_rdy, 1);
      chk("c_c6_waddr", o_rd_waddr, 1);
      tick;
      drive(1, 5'd1, 32'hAAAA, 0, 0, 0);
      chk("c_c7_mask", o_pend_mask, 32'h18);
      chk("c_c7_rdy", o_lu_rdy, 0);
      seen = 0;
      for (int n = 0; n < 20; n++) begin
         if (o_rd_wen && o_rd_waddr != 5'd1) begin
            if (seen < 2) got[seen] = o_rd_waddr;
            seen++;
         end
         tick;
      end
      chk("c_drain_count", seen, 2);
      chk("c_order_1", got[0], 3);
      chk("c_order_2", got[1], 4);
      chk("c_drain_mask", o_pend_mask, 0);
      // x0 on both sources
      drive(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
      chk("d_wen", o_rd_wen, 0);
      chk("d_rdy", o_lu_rdy, 1);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk("d_next_wen", o_rd_wen, 0);
      chk("d_mask", o_pend_mask, 0);
      // asynchronous reset with a full queue
      drive(1, 5'd1, 32'hAAAA, 1, 5'd8, 32'h88);
      tick;
      drive(1, 5'd1, 32'hAAAA, 1, 5'd9, 32'h99);
      tick;
      drive(1, 5'd1, 32'hAAAA, 0, 0, 0);
      chk("e_full_rdy", o_lu_rdy, 0);
      chk("e_full_mask", o_pend_mask, 32'h300);
      #1;
      i_rst = 1'b1;
      #1;
      chk("e_rst_wen", o_rd_wen, 0);
      chk("e_rst_rdy", o_lu_rdy, 0);
      chk("e_rst_stall", o_stall, 0);
      chk("e_rst_mask", o_pend_mask, 0);
      chk("e_rst_waddr", o_rd_waddr, 0);
      chk("e_rst_wdata", o_rd_wdata, 0);
      tick;
      i_rst = 1'b0;
      drive(0, 0, 0, 1, 5'd10, 32'hA0);
      chk("e_rel_rdy", o_lu_rdy, 1);
`ifdef WB_ARB_BYPASS_EN
      chk("e_rel_wen", o_rd_wen, 1);
      chk("e_rel_waddr", o_rd_waddr, 10);
      tick;
      drive(0, 0, 0, 0, 0, 0);
`else
      chk("e_rel_wen", o_rd_wen, 0);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk("e_first_wen", o_rd_wen, 1);
      chk("e_first_waddr", o_rd_waddr, 10);
      chk("e_first_wdata", o_rd_wdata, 32'hA0);
`endif
      nbad_addr = 0;
      for (int n = 0; n < 10; n++) begin
         tick;
         if (o_rd_wen && (o_rd_waddr == 5'd8 || o_rd_waddr == 5'd9)) nbad_addr++;
      end
      chk("e_dropped_writes", nbad_addr, 0);
      chk("e_end_mask", o_pend_mask, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/wb_wport_arb.md
WB_WPORT_ARB -- requirements
Module: wb_wport_arb

Interface
REQ-001 Parameter: DEPTH, 2, long-latency result queue entries (2..8).
REQ-002 Parameter: STARVE_MAX, 4, consecutive starved cycles before the stall request (1..15).
REQ-003 Port: i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: i_rst  in  1  reset; asynchronous, active-high.
REQ-005 Port: i_wb_wen  in  1  pipeline write-back write enable.
REQ-006 Port: i_wb_waddr  in  5  pipeline destination register.
REQ-007 Port: i_wb_wdata  in  32  pipeline write data (already ALU/memory-muxed).
REQ-008 Port: i_lu_vld  in  1  long-latency unit (mul/div) result valid.
REQ-009 Port: i_lu_waddr  in  5  long-latency unit destination register.
REQ-010 Port: i_lu_wdata  in  32  long-latency unit result.
REQ-011 Port: o_lu_rdy  out  1  arbiter can accept a long-latency result.
REQ-012 Port: o_rd_wen  out  1  register-file write enable.
REQ-013 Port: o_rd_waddr  out  5  register-file write address.
REQ-014 Port: o_rd_wdata  out  32  register-file write data.
REQ-015 Port: o_stall  out  1  request for the pipeline to hold its write-back instruction.
REQ-016 Port: o_pend_mask  out  32  bit n set while any queued entry targets xn.

Function
REQ-017 The block SHALL share the single register-file write port between the pipeline and the long-latency unit; o_rd_* are combinational from the inputs and the queue head.
REQ-018 An LU transfer SHALL occur on a cycle with i_lu_vld=1 and o_lu_rdy=1; o_lu_rdy = (count < DEPTH), from registered state only.
REQ-019 At full, o_lu_rdy SHALL be 0 even if a pop occurs that cycle (no push-through).
REQ-020 An accepted LU result with i_lu_waddr=0 SHALL be discarded, never queued.
REQ-021 A pipeline write with i_wb_waddr=0 SHALL be treated as no pipeline write (o_rd_wen not driven by it).
REQ-022 Priority with o_stall=0: a pipeline write SHALL win; otherwise the queue head, if any, SHALL be written and popped.
REQ-023 With o_stall=1: the queue head SHALL be written and popped; i_wb_* SHALL be ignored (the pipeline holds).
REQ-024 Queue order SHALL be FIFO; pointers wrap modulo DEPTH; a push and a pop in the same cycle leave count unchanged.
REQ-025 Starve counter: increments, saturating at STARVE_MAX, each cycle the queue is non-empty and not popped; clears to 0 on any pop or when the queue is empty.
REQ-026 o_stall = (starve counter == STARVE_MAX), registered.
REQ-027 o_pend_mask SHALL be the OR of one-hot(waddr) over valid entries, from registered state only (excludes same-cycle pushes).
REQ-028 o_rd_wen=0 whenever there is neither a valid pipeline write nor a queue entry to drain.

Reset
REQ-029 Asserting i_rst SHALL asynchronously clear count, pointers, all entry-valid bits and the starve counter.
REQ-030 While i_rst=1: o_rd_wen=0, o_lu_rdy=0, o_stall=0, o_pend_mask=0; o_rd_waddr and o_rd_wdata are 0.
REQ-031 Reset mid-operation SHALL drop all queued results; the first accept SHALL be possible on the first edge after deassertion.

Configuration
REQ-032 Macro WB_ARB_BYPASS_EN: when defined, an accepted LU result that arrives with the queue empty, no pipeline write and o_stall=0 SHALL be written in the same cycle and not queued (0-cycle latency).
REQ-033 Without WB_ARB_BYPASS_EN, every accepted nonzero-address LU result SHALL be queued; the minimum write latency is 1 cycle.

Verification
REQ-034 Idle pipeline, LU push x5=0x1234: bypass build writes x5 the same cycle; non-bypass build writes it next cycle with o_pend_mask=0x20 for one cycle.
REQ-035 Pipeline writes x1 every cycle and LU pushes x7 -> the queue holds x7 for 4 cycles, o_stall=1 on the 5th, x7 is written that cycle, and o_stall=0 the next.
REQ-036 DEPTH=2, three back-to-back LU pushes (x2, x3, x4) under continuous pipeline writes -> o_lu_rdy drops after the 2nd push; the 3rd is held until a pop frees a slot; written order is x2, x3, x4.
REQ-037 LU push to x0 and pipeline write to x0 in the same cycle -> o_rd_wen=0, count unchanged, no o_pend_mask bit set.
REQ-038 Queue full (x8, x9), assert i_rst mid-cycle -> all outputs drop immediately to their reset values; after release, o_lu_rdy=1 and neither x8 nor x9 is ever written.
